// File: rtl/dm_master_pkg.sv
// Shared encodings for the data-memory initiator: memory op codes,
// FSM states, address-exception codes and a small op classifier.
package dm_master_pkg;

    localparam int DM_ADDR_WIDTH = 14;

    typedef enum logic [2:0] {
        MOP_LW  = 3'd0,
        MOP_LH  = 3'd1,
        MOP_LHU = 3'd2,
        MOP_LB  = 3'd3,
        MOP_LBU = 3'd4,
        MOP_SW  = 3'd5,
        MOP_SH  = 3'd6,
        MOP_SB  = 3'd7
    } mop_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } dm_state_e;

    localparam logic [4:0] EXC_ADEL = 5'd4;
    localparam logic [4:0] EXC_ADES = 5'd5;

    // True for the three store ops; everything else is a load.
    function automatic logic mop_is_store(input mop_e op);
        return (op == MOP_SW) || (op == MOP_SH) || (op == MOP_SB);
    endfunction

endpackage

// File: rtl/dm_master_if.sv
// Pipeline request/response and DM bus signals of the data-memory initiator.
// The master modport is the dm_master view; slave is the environment view.
interface dm_master_if;
    import dm_master_pkg::*;

    // pipeline request
    logic        req_valid;
    mop_e        req_op;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [31:0] req_pc;
    // pipeline response
    logic        stall;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_exc;
    logic [4:0]  rsp_exc_code;
    logic [31:0] rsp_badvaddr;
    // DM bus
    logic        dm_ce;
    logic        dm_re;
    logic        dm_we;
    logic [3:0]  dm_be;
    logic [31:0] dm_addr;
    logic [31:0] dm_din;
    logic [31:0] dm_pc;
    logic [31:0] dm_dout;
    logic        dm_ready;

    modport master (
        input  req_valid, req_op, req_addr, req_wdata, req_pc, dm_dout, dm_ready,
        output stall, rsp_valid, rsp_rdata, rsp_exc, rsp_exc_code, rsp_badvaddr,
        output dm_ce, dm_re, dm_we, dm_be, dm_addr, dm_din, dm_pc
    );

    modport slave (
        output req_valid, req_op, req_addr, req_wdata, req_pc, dm_dout, dm_ready,
        input  stall, rsp_valid, rsp_rdata, rsp_exc, rsp_exc_code, rsp_badvaddr,
        input  dm_ce, dm_re, dm_we, dm_be, dm_addr, dm_din, dm_pc
    );

endinterface

// File: rtl/dm_lane_align.sv
// Combinational lane logic for the data-memory initiator: address fault
// check and store byte-enable/data replication on the request side, and
// lane extraction with sign/zero extension on the load-return side.
module dm_lane_align
    import dm_master_pkg::*;
#(
    parameter int ADDR_WIDTH = DM_ADDR_WIDTH
) (
    input  mop_e        req_op,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        fault,
    output logic [3:0]  be,
    output logic [31:0] din,
    input  mop_e        ld_op,
    input  logic [1:0]  ld_lane,
    input  logic [31:0] dout,
    output logic [31:0] ld_data
);

    logic        misaligned_s;
    logic        out_of_range_s;
    logic [7:0]  byte_s;
    logic [15:0] half_s;

    // Natural alignment: halfwords on even, words on 4-byte boundaries.
    always_comb begin
        misaligned_s = 1'b0;
        case (req_op)
            MOP_LW, MOP_SW:          misaligned_s = (req_addr[1:0] != 2'b00);
            MOP_LH, MOP_LHU, MOP_SH: misaligned_s = req_addr[0];
            default:                 misaligned_s = 1'b0;
        endcase
    end

    assign out_of_range_s = |req_addr[31:ADDR_WIDTH];
    assign fault          = misaligned_s | out_of_range_s;

    // Store data is replicated across lanes; be selects the lanes written.
    always_comb begin
        be  = 4'b0000;
        din = 32'h0000_0000;
        case (req_op)
            MOP_SB: begin
                be  = 4'b0001 << req_addr[1:0];
                din = {4{req_wdata[7:0]}};
            end
            MOP_SH: begin
                be  = req_addr[1] ? 4'b1100 : 4'b0011;
                din = {2{req_wdata[15:0]}};
            end
            MOP_SW: begin
                be  = 4'b1111;
                din = req_wdata;
            end
            default: begin
                be  = 4'b0000;
                din = 32'h0000_0000;
            end
        endcase
    end

    // Pick the addressed lane of the returned word and extend it; stores return 0.
    always_comb begin
        byte_s  = 8'h00;
        ld_data = 32'h0000_0000;
        case (ld_lane)
            2'd0:    byte_s = dout[7:0];
            2'd1:    byte_s = dout[15:8];
            2'd2:    byte_s = dout[23:16];
            2'd3:    byte_s = dout[31:24];
            default: byte_s = 8'h00;
        endcase
        if (ld_lane[1]) begin
            half_s = dout[31:16];
        end else begin
            half_s = dout[15:0];
        end
        case (ld_op)
            MOP_LW:  ld_data = dout;
            MOP_LH:  ld_data = {{16{half_s[15]}}, half_s};
            MOP_LHU: ld_data = {16'h0000, half_s};
            MOP_LB:  ld_data = {{24{byte_s[7]}}, byte_s};
            MOP_LBU: ld_data = {24'h00_0000, byte_s};
            default: ld_data = 32'h0000_0000;
        endcase
    end

endmodule

// File: rtl/dm_master.sv
// Data-memory initiator in the MEM stage. Turns one pipeline load/store
// into a held DM request, waits for dm_ready, and returns a one-cycle
// response; faulting addresses are answered without touching DM.
module dm_master
    import dm_master_pkg::*;
#(
    parameter int ADDR_WIDTH = DM_ADDR_WIDTH
) (
    input logic         clk,
    input logic         reset,
    dm_master_if.master bus
);

    dm_state_e   state_r;
    dm_state_e   next_state_s;
    mop_e        op_r;

    logic        fault_s;
    logic [3:0]  be_s;
    logic [31:0] din_s;
    logic [31:0] ld_data_s;
    logic        req_store_s;
    logic        accept_s;
    logic        done_s;

    logic        dm_ce_r;
    logic        dm_re_r;
    logic        dm_we_r;
    logic [3:0]  dm_be_r;
    logic [31:0] dm_addr_r;
    logic [31:0] dm_din_r;
    logic [31:0] dm_pc_r;
    logic        rsp_valid_r;
    logic [31:0] rsp_rdata_r;
    logic        rsp_exc_r;
    logic [4:0]  rsp_exc_code_r;
    logic [31:0] rsp_badvaddr_r;

    dm_lane_align #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_lane_align (
        .req_op    (bus.req_op),
        .req_addr  (bus.req_addr),
        .req_wdata (bus.req_wdata),
        .fault     (fault_s),
        .be        (be_s),
        .din       (din_s),
        .ld_op     (op_r),
        .ld_lane   (dm_addr_r[1:0]),
        .dout      (bus.dm_dout),
        .ld_data   (ld_data_s)
    );

    assign req_store_s = mop_is_store(bus.req_op);
    assign accept_s    = (state_r == ST_IDLE) && bus.req_valid;
    assign done_s      = (state_r == ST_ACCESS) && bus.dm_ready;

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next state: faults skip ACCESS; RESP always lasts one cycle.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (bus.req_valid) begin
                    next_state_s = fault_s ? ST_RESP : ST_ACCESS;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_ACCESS: begin
                if (bus.dm_ready) begin
                    next_state_s = ST_RESP;
                end else begin
                    next_state_s = ST_ACCESS;
                end
            end
            ST_RESP: next_state_s = ST_IDLE;
            default: next_state_s = ST_IDLE;
        endcase
    end

    // DM request and response registers; response fields are 0 except in the RESP cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            op_r           <= MOP_LW;
            dm_ce_r        <= 1'b0;
            dm_re_r        <= 1'b0;
            dm_we_r        <= 1'b0;
            dm_be_r        <= 4'b0000;
            dm_addr_r      <= 32'h0000_0000;
            dm_din_r       <= 32'h0000_0000;
            dm_pc_r        <= 32'h0000_0000;
            rsp_valid_r    <= 1'b0;
            rsp_rdata_r    <= 32'h0000_0000;
            rsp_exc_r      <= 1'b0;
            rsp_exc_code_r <= 5'd0;
            rsp_badvaddr_r <= 32'h0000_0000;
        end else begin
            rsp_valid_r    <= 1'b0;
            rsp_rdata_r    <= 32'h0000_0000;
            rsp_exc_r      <= 1'b0;
            rsp_exc_code_r <= 5'd0;
            rsp_badvaddr_r <= 32'h0000_0000;
            if (accept_s && fault_s) begin
                rsp_valid_r    <= 1'b1;
                rsp_exc_r      <= 1'b1;
                rsp_exc_code_r <= req_store_s ? EXC_ADES : EXC_ADEL;
                rsp_badvaddr_r <= bus.req_addr;
            end else if (accept_s) begin
                op_r      <= bus.req_op;
                dm_ce_r   <= 1'b1;
                dm_re_r   <= ~req_store_s;
                dm_we_r   <= req_store_s;
                dm_be_r   <= be_s;
                dm_addr_r <= bus.req_addr;
                dm_din_r  <= din_s;
                dm_pc_r   <= bus.req_pc;
            end else if (done_s) begin
                dm_ce_r     <= 1'b0;
                dm_re_r     <= 1'b0;
                dm_we_r     <= 1'b0;
                dm_be_r     <= 4'b0000;
                dm_addr_r   <= 32'h0000_0000;
                dm_din_r    <= 32'h0000_0000;
                dm_pc_r     <= 32'h0000_0000;
                rsp_valid_r <= 1'b1;
                rsp_rdata_r <= ld_data_s;
            end else if (state_r != ST_ACCESS) begin
                dm_ce_r   <= 1'b0;
                dm_re_r   <= 1'b0;
                dm_we_r   <= 1'b0;
                dm_be_r   <= 4'b0000;
                dm_addr_r <= 32'h0000_0000;
                dm_din_r  <= 32'h0000_0000;
                dm_pc_r   <= 32'h0000_0000;
            end
        end
    end

    // Stall must act in the same cycle the request appears, so it stays combinational.
    assign bus.stall        = bus.req_valid & ~rsp_valid_r & ~reset;
    assign bus.rsp_valid    = rsp_valid_r;
    assign bus.rsp_rdata    = rsp_rdata_r;
    assign bus.rsp_exc      = rsp_exc_r;
    assign bus.rsp_exc_code = rsp_exc_code_r;
    assign bus.rsp_badvaddr = rsp_badvaddr_r;
    assign bus.dm_ce        = dm_ce_r;
    assign bus.dm_re        = dm_re_r;
    assign bus.dm_we        = dm_we_r;
    assign bus.dm_be        = dm_be_r;
    assign bus.dm_addr      = dm_addr_r;
    assign bus.dm_din       = dm_din_r;
    assign bus.dm_pc        = dm_pc_r;

endmodule

// File: tb/tb_dm_master.sv
// Bench for dm_master: a byte-array DM model with programmable ready delay,
// and a separate byte-array reference memory from which expected load data,
// byte enables, store data, exceptions and latencies are computed.
module tb_dm_master;
    import dm_master_pkg::*;

    localparam int AW        = 14;
    localparam int MEM_BYTES = 1 << AW;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    dm_master_if bus();

    dm_master #(.ADDR_WIDTH(AW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    logic [7:0]  dm_mem  [MEM_BYTES];
    logic [7:0]  ref_mem [MEM_BYTES];
    logic        mem_loaded = 1'b0;
    int          ready_lat  = 0;
    int          ready_cnt  = 0;
    int          tests_run    = 0;
    int          tests_failed = 0;
    logic [31:0] last_rdata, last_be, last_din, last_exc, last_code, last_badv;

    function automatic logic [7:0] init_byte(input int i);
        return 8'((i * 73 + 29) ^ (i >> 7));
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // DM model write port: commits enabled bytes on an edge where ready is high.
    always @(posedge clk) begin
        if (!mem_loaded) begin
            for (int i = 0; i < MEM_BYTES; i++) dm_mem[i] <= init_byte(i);
            mem_loaded <= 1'b1;
        end else if (bus.dm_ce && bus.dm_we && bus.dm_ready) begin
            for (int b = 0; b < 4; b++)
                if (bus.dm_be[b]) dm_mem[int'(bus.dm_addr[AW-1:2]) * 4 + b] <= bus.dm_din[8*b +: 8];
        end
    end

    // DM model response side: ready after ready_lat low cycles, word read data.
    always @(negedge clk) begin
        if (bus.dm_ce) begin
            int w;
            w = int'(bus.dm_addr[AW-1:2]) * 4;
            bus.dm_ready <= (ready_cnt == ready_lat);
            ready_cnt    <= ready_cnt + 1;
            bus.dm_dout  <= {dm_mem[w+3], dm_mem[w+2], dm_mem[w+1], dm_mem[w]};
        end else begin
            ready_cnt    <= 0;
            bus.dm_ready <= 1'b0;
            bus.dm_dout  <= 32'h0000_0000;
        end
    end

    task automatic do_op(input mop_e op, input logic [31:0] addr, input logic [31:0] wdata, input int lat);
        int          size, cycles, ce_cycles;
        bit          store, sgn, fault, seen, unstable;
        logic [31:0] exp_rdata, exp_be, exp_din, val, pc;
        logic [31:0] f_addr, f_din, f_pc;
        logic [3:0]  f_be;
        logic        f_re, f_we;

        pc = $urandom;
        case (op)
            MOP_LW, MOP_SW:          size = 4;
            MOP_LH, MOP_LHU, MOP_SH: size = 2;
            default:                 size = 1;
        endcase
        store = (op == MOP_SW) || (op == MOP_SH) || (op == MOP_SB);
        sgn   = (op == MOP_LH) || (op == MOP_LB);
        fault = ((addr % size) != 0) || (addr >= MEM_BYTES);

        exp_be = 0; exp_din = 0; exp_rdata = 0;
        if (!fault && store) begin
            exp_be  = ((32'd1 << size) - 32'd1) << (addr % 4);
            exp_din = (size == 1) ? {24'h0, wdata[7:0]} * 32'h0101_0101 :
                      (size == 2) ? {16'h0, wdata[15:0]} * 32'h0001_0001 : wdata;
        end
        if (!fault && !store) begin
            val = 0;
            for (int i = 0; i < size; i++) val = val | ({24'h0, ref_mem[addr + i]} << (8 * i));
            if (sgn && val[8*size-1]) val = val | ~((32'd1 << (8 * size)) - 32'd1);
            exp_rdata = val;
        end

        ready_lat = lat;
        @(negedge clk);
        bus.req_valid = 1'b1; bus.req_op = op; bus.req_addr = addr;
        bus.req_wdata = wdata; bus.req_pc = pc;
        #1;
        check_eq("stall_on_req", bus.stall, 1);

        seen = 0; cycles = 0; ce_cycles = 0; unstable = 0;
        f_addr = 0; f_din = 0; f_pc = 0; f_be = 0; f_re = 0; f_we = 0;
        while (!seen && cycles < 40) begin
            @(posedge clk); #1;
            cycles++;
            if (bus.rsp_valid) begin
                seen = 1;
            end else begin
                if (!bus.stall) unstable = 1;
                if (bus.dm_ce) begin
                    if (ce_cycles == 0) begin
                        f_addr = bus.dm_addr; f_din = bus.dm_din; f_pc = bus.dm_pc;
                        f_be = bus.dm_be; f_re = bus.dm_re; f_we = bus.dm_we;
                    end else if (f_addr !== bus.dm_addr || f_din !== bus.dm_din || f_pc !== bus.dm_pc ||
                                 f_be !== bus.dm_be || f_re !== bus.dm_re || f_we !== bus.dm_we) begin
                        unstable = 1;
                    end
                    ce_cycles++;
                end
            end
        end

        check_eq("rsp_seen", seen, 1);
        check_eq("latency", cycles, fault ? 1 : lat + 2);
        check_eq("ce_cycles", ce_cycles, fault ? 0 : lat + 1);
        check_eq("access_stable", unstable, 0);
        check_eq("rsp_exc", bus.rsp_exc, fault);
        check_eq("rsp_exc_code", bus.rsp_exc_code, fault ? (store ? 5 : 4) : 0);
        check_eq("rsp_badvaddr", bus.rsp_badvaddr, fault ? addr : 0);
        check_eq("rsp_rdata", bus.rsp_rdata, exp_rdata);
        if (!fault) begin
            check_eq("dm_addr", f_addr, addr);
            check_eq("dm_pc", f_pc, pc);
            check_eq("dm_be", f_be, exp_be);
            check_eq("dm_din", f_din, exp_din);
            check_eq("dm_re_we", {f_re, f_we}, store ? 2'b01 : 2'b10);
        end

        if (!fault && store)
            for (int i = 0; i < size; i++) ref_mem[addr + i] = wdata[8*i +: 8];

        last_rdata = bus.rsp_rdata; last_be = f_be; last_din = f_din;
        last_exc = bus.rsp_exc; last_code = bus.rsp_exc_code; last_badv = bus.rsp_badvaddr;

        bus.req_valid = 1'b0;
        @(posedge clk); #1;
        check_eq("rsp_one_cycle", {bus.rsp_valid, bus.rsp_exc, bus.stall}, 0);
        check_eq("rsp_rdata_idle", bus.rsp_rdata, 0);
    endtask

    initial begin
        logic [31:0] a, old_word;
        mop_e        op;

        for (int i = 0; i < MEM_BYTES; i++) ref_mem[i] = init_byte(i);
        bus.req_valid = 1'b1; bus.req_op = MOP_LW; bus.req_addr = 32'h0;
        bus.req_wdata = 32'h0; bus.req_pc = 32'h0;

        repeat (3) @(negedge clk);
        check_eq("reset_stall", bus.stall, 0);
        check_eq("reset_rsp", {bus.rsp_valid, bus.rsp_exc, bus.dm_ce, bus.dm_re, bus.dm_we}, 0);
        check_eq("reset_dm_addr", bus.dm_addr, 0);
        bus.req_valid = 1'b0;
        reset = 1'b0;

        // directed cases
        do_op(MOP_SW, 32'h10, 32'hDEADBEEF, 0);
        check_eq("sw10_be", last_be, 32'hF);
        check_eq("sw10_din", last_din, 32'hDEADBEEF);
        do_op(MOP_LW, 32'h10, 32'h0, 1);
        check_eq("lw10_data", last_rdata, 32'hDEADBEEF);
        do_op(MOP_SB, 32'h13, 32'h0000_00A5, 0);
        check_eq("sb13_be", last_be, 32'h8);
        check_eq("sb13_din", last_din, 32'hA5A5A5A5);
        do_op(MOP_LB, 32'h13, 32'h0, 0);
        check_eq("lb13_data", last_rdata, 32'hFFFFFFA5);
        do_op(MOP_LBU, 32'h13, 32'h0, 2);
        check_eq("lbu13_data", last_rdata, 32'h000000A5);
        do_op(MOP_SH, 32'h22, 32'h0000_8001, 0);
        check_eq("sh22_be", last_be, 32'hC);
        do_op(MOP_LH, 32'h22, 32'h0, 0);
        check_eq("lh22_data", last_rdata, 32'hFFFF8001);
        do_op(MOP_LHU, 32'h22, 32'h0, 0);
        check_eq("lhu22_data", last_rdata, 32'h00008001);
        do_op(MOP_LW, 32'h11, 32'h0, 0);
        check_eq("lw11_exc", {last_exc[0], last_code[4:0]}, {1'b1, 5'd4});
        check_eq("lw11_badv", last_badv, 32'h11);
        do_op(MOP_SH, 32'h05, 32'h1234, 0);
        check_eq("sh05_code", last_code, 32'd5);
        do_op(MOP_SW, 32'h0001_0000, 32'h1, 0);
        check_eq("sw_oor_code", last_code, 32'd5);
        do_op(MOP_SW, 32'h24, 32'hCAFEF00D, 5);
        do_op(MOP_LW, 32'h24, 32'h0, 0);
        check_eq("lw24_data", last_rdata, 32'hCAFEF00D);

        // reset in the middle of a store that never sees ready
        old_word = {ref_mem[32'h43], ref_mem[32'h42], ref_mem[32'h41], ref_mem[32'h40]};
        ready_lat = 1000;
        @(negedge clk);
        bus.req_valid = 1'b1; bus.req_op = MOP_SW; bus.req_addr = 32'h40;
        bus.req_wdata = 32'h12345678; bus.req_pc = 32'h100;
        repeat (3) @(posedge clk);
        #2;
        check_eq("pre_reset_ce", bus.dm_ce, 1);
        reset = 1'b1;
        #1;
        check_eq("rst_dm_ctl", {bus.dm_ce, bus.dm_re, bus.dm_we, bus.dm_be}, 0);
        check_eq("rst_dm_addr", bus.dm_addr, 0);
        check_eq("rst_dm_din", bus.dm_din, 0);
        check_eq("rst_dm_pc", bus.dm_pc, 0);
        check_eq("rst_stall", bus.stall, 0);
        check_eq("rst_rsp", {bus.rsp_valid, bus.rsp_exc, bus.rsp_exc_code}, 0);
        bus.req_valid = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        do_op(MOP_LW, 32'h40, 32'h0, 0);
        check_eq("lw_after_rst", last_rdata, old_word);

        // randomized traffic
        for (int n = 0; n < 300; n++) begin
            op = mop_e'($urandom_range(0, 7));
            if ($urandom_range(0, 9) == 0) a = $urandom;
            else a = 32'($urandom_range(0, 255));
            do_op(op, a, $urandom, $urandom_range(0, 3));
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
